// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

   // Two-state controller: waiting for a request, or stepping through bits.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when b exceeds a, or when they are equal and a borrow arrives.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first,
// through a single full subtractor. Results (Diff, Bo, V) update together
// with a one-cycle done pulse and otherwise hold their last values.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bo,
   output logic             V
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Holds the low WIDTH-1 difference bits gathered so far; the final bit
   // comes straight from the full subtractor on the last step.
   logic [WIDTH-2:0] diff_sr;
   logic             br_q;
   logic             done_q;
   logic             d_bit;
   logic             br_next;
   logic             cnt_last;
   logic [WIDTH-1:0] diff_next;

   full_subtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br_q),
      .d    (d_bit),
      .bout (br_next)
   );

   assign cnt_last  = (cnt_q == LAST);
   assign diff_next = {d_bit, diff_sr};

   // State register.
   // NOTE: reset is synchronous, so it lives inside the clocked branch and
   // sequential state is always assigned with <= to avoid ordering races.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: accept start only when idle, leave after the MSB.
   // NOTE: state_d gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)    state_d = SHIFT;
         SHIFT:   if (cnt_last) state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Status outputs derived from the current state and the completion flag.
   always_comb begin
      busy = (state_q == SHIFT);
      done = done_q;
   end

   // Datapath: operand shift registers, borrow chain, counter and results.
   // NOTE: the operand and difference shift registers are reset along with
   // the control state, so an aborted operation leaves no stale bits behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         br_q    <= 1'b0;
         done_q  <= 1'b0;
         Diff    <= '0;
         Bo      <= 1'b0;
         V       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sr    <= A;
                  b_sr    <= B;
                  br_q    <= Bin;
                  cnt_q   <= '0;
                  diff_sr <= '0;
               end
            end
            SHIFT: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               br_q    <= br_next;
               diff_sr <= diff_next[WIDTH-1:1];
               cnt_q   <= cnt_last ? '0 : cnt_q + CW'(1);
               if (cnt_last) begin
                  // br_q is the borrow into the MSB; overflow is its
                  // disagreement with the borrow out of the MSB.
                  Diff   <= diff_next;
                  Bo     <= br_next;
                  V      <= br_q ^ br_next;
                  done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4). A transaction-level
// model predicts busy/done/results every cycle from plain integer arithmetic;
// directed cases pin the model with hand-computed literals.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bo;
   logic         V;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bo    (Bo),
      .V     (V)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic: unsigned difference/borrow and signed overflow.
   function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, output logic [W-1:0] d,
                                   output logic bo, output logic v);
      int ua, ub, sa, sb, res;
      ua  = int'(a);
      ub  = int'(b);
      sa  = (ua >= 8) ? ua - 16 : ua;
      sb  = (ub >= 8) ? ub - 16 : ub;
      res = sa - sb - int'(bin);
      d   = W'((ua - ub - int'(bin)) & 15);
      bo  = (ua < ub + int'(bin));
      v   = (res < -8) || (res > 7);
   endfunction

   // Transaction model: an accepted start makes the unit busy for W edges,
   // then results appear with a done pulse.
   int           m_rem = 0;
   logic         m_busy, m_done, m_bo, m_v, h_bin;
   logic [W-1:0] m_diff, h_a, h_b;

   always @(posedge clk) begin
      if (rst) begin
         m_rem  = 0;
         m_done = 1'b0;
         m_diff = '0;
         m_bo   = 1'b0;
         m_v    = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               ref_sub(h_a, h_b, h_bin, m_diff, m_bo, m_v);
               m_done = 1'b1;
            end
         end else if (start) begin
            h_a   = A;
            h_b   = B;
            h_bin = Bin;
            m_rem = W;
         end
      end
      m_busy = (m_rem > 0);
   end

   // Per-cycle comparison of every output against the model.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("busy", 32'(busy), int'(m_busy));
         check("done", 32'(done), int'(m_done));
         check("Diff", 32'(Diff), int'(m_diff));
         check("Bo",   32'(Bo),   int'(m_bo));
         check("V",    32'(V),    int'(m_v));
      end
   end

   // Issue one operation; optionally re-pulse start (A=B=0) at iteration
   // 'glitch' while busy. Checks latency, busy length and results.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int glitch, input logic [W-1:0] ed, input logic ebo,
                        input logic ev, input string nm);
      int lat;
      int busy_cnt;
      lat      = 0;
      busy_cnt = 0;
      @(negedge clk);
      A     = a;
      B     = b;
      Bin   = bin;
      start = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (i == glitch) begin
            start = 1'b1;
            A     = '0;
            B     = '0;
         end else begin
            start = 1'b0;
            A     = W'($urandom);
            B     = W'($urandom);
            Bin   = 1'($urandom);
         end
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      check({nm, "/latency"}, 32'(lat), W);
      check({nm, "/busy_cycles"}, 32'(busy_cnt), W);
      check({nm, "/Diff"}, 32'(Diff), int'(ed));
      check({nm, "/Bo"}, 32'(Bo), int'(ebo));
      check({nm, "/V"}, 32'(V), int'(ev));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ed;
      logic         ebo, ev;
      int           ndone;

      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      Bin   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset/busy", 32'(busy), 0);
      check("reset/done", 32'(done), 0);
      check("reset/Diff", 32'(Diff), 0);
      check("reset/Bo",   32'(Bo),   0);
      check("reset/V",    32'(V),    0);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Directed cases with hand-computed results.
      do_op(4'd7, 4'd3, 1'b0, 0, 4'd4,  1'b0, 1'b0, "7-3");
      do_op(4'd3, 4'd5, 1'b1, 0, 4'd13, 1'b1, 1'b0, "3-5-1");
      do_op(4'd8, 4'd1, 1'b0, 0, 4'd7,  1'b0, 1'b1, "neg_ovf");
      do_op(4'd7, 4'd15, 1'b0, 0, 4'd8, 1'b1, 1'b1, "pos_ovf");
      do_op(4'd9, 4'd3, 1'b0, 2, 4'd6,  1'b0, 1'b1, "start_while_busy");

      // Abort: reset sampled two edges after the accepting edge.
      @(negedge clk);
      A = 4'd7; B = 4'd3; Bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort/busy", 32'(busy), 0);
      check("abort/Diff", 32'(Diff), 0);
      check("abort/Bo",   32'(Bo),   0);
      check("abort/V",    32'(V),    0);
      @(negedge clk);
      rst   = 1'b0;
      ndone = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check("abort/no_done", 32'(ndone), 0);
      do_op(4'd0, 4'd1, 1'b0, 0, 4'd15, 1'b1, 1'b0, "after_abort");

      // Reset and start together: reset wins.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; A = 4'd5; B = 4'd1;
      @(posedge clk);
      #1;
      check("rst_and_start/busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0; start = 1'b0;

      // Back-to-back: second start lands in the done cycle.
      do_op(4'd7, 4'd3, 1'b0, 0, 4'd4,  1'b0, 1'b0, "b2b_first");
      do_op(4'd2, 4'd2, 1'b1, 0, 4'd15, 1'b1, 1'b0, "b2b_second");

      // Exhaustive sweep of all operand / borrow-in combinations.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v9;
         v9 = 9'(i);
         ref_sub(v9[3:0], v9[7:4], v9[8], ed, ebo, ev);
         do_op(v9[3:0], v9[7:4], v9[8], 0, ed, ebo, ev, "sweep");
      end

      // Random operations with idle gaps and stray start pulses while busy.
      for (int i = 0; i < 150; i++) begin
         logic [W-1:0] ra, rb;
         logic         rbin;
         int           gap;
         ra   = W'($urandom);
         rb   = W'($urandom);
         rbin = 1'($urandom);
         gap  = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         ref_sub(ra, rb, rbin, ed, ebo, ev);
         do_op(ra, rb, rbin, $urandom_range(0, 4), ed, ebo, ev, "random");
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Sequential bit-serial subtractor, the subtract-direction counterpart to the team's ripple adder.
- Latches two WIDTH-bit operands and a borrow-in on a start strobe.
- Produces one difference bit per clock, LSB first, through a single 1-bit full subtractor.
- Reports difference, borrow-out and signed overflow with a one-cycle done pulse.
- Used in area-constrained datapaths where a full-width subtractor is not justified.

Parameters:
- WIDTH, 4, operand and difference width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a new subtraction; sampled only when idle.
- A  input  WIDTH  minuend, sampled on accepted start.
- B  input  WIDTH  subtrahend, sampled on accepted start.
- Bin  input  1  borrow-in, sampled on accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when results update.
- Diff  output  WIDTH  (A - B - Bin) mod 2^WIDTH.
- Bo  output  1  borrow-out; 1 iff A < B + Bin (unsigned).
- V  output  1  two's-complement overflow.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset, on the rst edge:
  - state=IDLE, bit counter=0.
  - busy=0, done=0, Diff=0, Bo=0, V=0.
  - Operand shift registers cleared.
- States:
  - IDLE: busy=0. On start=1, latch A, B and Bin into the shift registers and internal borrow, clear counter, go to SHIFT.
  - SHIFT: busy=1. Each edge processes bit[cnt] and shifts the result bit into the Diff shift register.
    - d = a ^ b ^ br.
    - br_next = (~a & b) | (~(a ^ b) & br).
    - cnt increments each edge.
    - On the edge processing cnt=WIDTH-1: latch Diff, Bo=br_next, V=br_in_msb ^ br_next; done=1 for the following cycle; go to IDLE.
- Latency: start sampled at edge k; done high and results valid after edge k+WIDTH; done low again after edge k+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles. Back-to-back is allowed: start asserted during the done cycle (state IDLE) is accepted.
- Diff, Bo and V hold their last completed values until the next completion. They never show partial results.
- start while busy=1 is ignored. Operands are not re-sampled and the timing is unaffected.
- A, B and Bin may change freely after the accepting edge.
- rst during SHIFT aborts the operation: no done pulse, outputs reset to 0.
- rst and start in the same cycle: rst wins, start is dropped.
- Wrap-around: Diff is modulo 2^WIDTH. For example, 0 - 1 with WIDTH=4 gives Diff=15, Bo=1.
- Counter width: $clog2(WIDTH)+1 bits. It never exceeds WIDTH-1 in SHIFT.

Decomposition:
- Shared package serial_sub_pkg holds:
  - state encoding constants: IDLE=1'b0, SHIFT=1'b1.
  - default WIDTH constant.
- One combinational sub-module, full_subtractor (a, b, bin -> d, bout), instantiated once for the per-bit step.
- Everything else is in the top-level FSM/datapath.

Test Plan (WIDTH=4; check done timing at edge k+4 in every case):
- A=7, B=3, Bin=0, start -> Diff=4, Bo=0, V=0.
- A=3, B=5, Bin=1, start -> Diff=13, Bo=1, V=0.
- A=8, B=1, Bin=0 -> Diff=7, Bo=0, V=1 (negative overflow). Then A=7, B=15, Bin=0 -> Diff=8, Bo=1, V=1 (positive overflow).
- Start A=9, B=3. Pulse start again with A=0, B=0 two cycles later -> second start ignored; Diff=6, Bo=0, V=1; busy high for exactly 4 cycles.
- Start A=7, B=3. Assert rst at cycle 2 -> no done pulse, all outputs 0. Then start A=0, B=1, Bin=0 -> Diff=15, Bo=1, V=0.
- Back-to-back: start A=7, B=3; assert start with A=2, B=2, Bin=1 in the done cycle -> first result 4, second done 5 cycles later with Diff=15, Bo=1, V=0.
- Sweep (all cases): all 512 combinations of A, B, Bin compared against a behavioural A-B-Bin model.
